// File: rtl/rv_scoreboard.sv
// Register-busy scoreboard for an in-order pipeline: tracks fixed- and variable-latency
// writes per register and raises issue_ready when no RAW, WAW or capacity hazard exists.
module rv_scoreboard #(
  parameter int REG_AW  = 4,
  parameter int LAT_W   = 3,
  parameter int MAX_OUT = 4,
  parameter int BYPASS  = 1,
  localparam int NREG   = 1 << REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_rs1_used,
  input  logic              issue_rs2_used,
  input  logic              issue_we,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              flush,
  input  logic              done_valid,
  input  logic [REG_AW-1:0] done_rd,
  output logic              issue_ready,
  output logic [NREG-1:0]   pending,
  output logic [REG_AW:0]   outstanding,
  output logic              err
);

  logic [NREG-1:0]  pending_q, pending_d;
  logic [NREG-1:0]  var_q, var_d;
  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [REG_AW:0]  outstanding_q, outstanding_d;
  logic             err_q, err_d;

  logic [NREG-1:0]  clear_now;
  logic [NREG-1:0]  released;
  logic [REG_AW:0]  rel_cnt;
  logic             src1_haz, src2_haz, waw_haz, cap_haz;
  logic             accept, do_write;

  always_comb begin
    clear_now = '0;
    rel_cnt   = '0;
    for (int r = 0; r < NREG; r++) begin
      if (pending_q[r]) begin
        clear_now[r] = var_q[r] ? (done_valid && (done_rd == REG_AW'(r)))
                                : (cnt_q[r] == LAT_W'(1));
      end
    end
    // Completions only unblock dependents in the same cycle when bypassing.
    released = (BYPASS != 0) ? clear_now : '0;
    for (int r = 0; r < NREG; r++) begin
      rel_cnt = rel_cnt + (REG_AW+1)'(released[r]);
    end

    src1_haz = issue_rs1_used && (issue_rs1 != '0) && pending_q[issue_rs1] && !released[issue_rs1];
    src2_haz = issue_rs2_used && (issue_rs2 != '0) && pending_q[issue_rs2] && !released[issue_rs2];
    waw_haz  = issue_we && (issue_rd != '0) && pending_q[issue_rd] && !released[issue_rd];
    cap_haz  = issue_we && (issue_rd != '0) &&
               ((outstanding_q - rel_cnt) >= (REG_AW+1)'(MAX_OUT));

    issue_ready = !(src1_haz || src2_haz || waw_haz || cap_haz);
    accept      = issue_valid && issue_ready && !flush;
    do_write    = accept && issue_we && (issue_rd != '0);
  end

  always_comb begin
    pending_d = pending_q;
    var_d     = var_q;
    cnt_d     = cnt_q;
    for (int r = 0; r < NREG; r++) begin
      if (pending_q[r]) begin
        if (clear_now[r]) begin
          pending_d[r] = 1'b0;
          var_d[r]     = 1'b0;
          cnt_d[r]     = '0;
        end else if (!var_q[r] && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
      end
    end
    // A new write overrides a same-cycle release of the same register.
    if (do_write) begin
      pending_d[issue_rd] = 1'b1;
      cnt_d[issue_rd]     = issue_lat;
      var_d[issue_rd]     = (issue_lat == '0);
    end
    pending_d[0] = 1'b0;
    var_d[0]     = 1'b0;

    outstanding_d = '0;
    for (int r = 0; r < NREG; r++) begin
      outstanding_d = outstanding_d + (REG_AW+1)'(pending_d[r]);
    end

    err_d = err_q;
    if (done_valid && ((done_rd == '0) || !pending_q[done_rd] || !var_q[done_rd])) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q     <= '0;
      var_q         <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      pending_q     <= pending_d;
      var_q         <= var_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

endmodule

// File: tb/tb_rv_scoreboard.sv
// Scenario bench for rv_scoreboard (default parameters, BYPASS=1): each cycle's expected
// {ready, pending, outstanding, err} is queued when stimulus is driven and popped at sampling.
module tb_rv_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_rs1, issue_rs2;
  logic        issue_rs1_used, issue_rs2_used;
  logic        issue_we;
  logic [3:0]  issue_rd;
  logic [2:0]  issue_lat;
  logic        flush;
  logic        done_valid;
  logic [3:0]  done_rd;
  logic        issue_ready;
  logic [15:0] pending;
  logic [4:0]  outstanding;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    bit         v, fl, we;
    bit [3:0]   rd;
    bit [2:0]   lat;
    bit         u1;
    bit [3:0]   rs1;
    bit         u2;
    bit [3:0]   rs2;
    bit         dv;
    bit [3:0]   drd;
    bit [22:0]  exp;
  } row_t;

  typedef struct {
    string     name;
    bit [22:0] val;
  } exp_t;

  exp_t exp_q[$];

  rv_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2_used (issue_rs2_used),
    .issue_we       (issue_we),
    .issue_rd       (issue_rd),
    .issue_lat      (issue_lat),
    .flush          (flush),
    .done_valid     (done_valid),
    .done_rd        (done_rd),
    .issue_ready    (issue_ready),
    .pending        (pending),
    .outstanding    (outstanding),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic row_t mk(string name, bit v, bit fl, bit we, bit [3:0] rd, bit [2:0] lat,
                              bit u1, bit [3:0] rs1, bit u2, bit [3:0] rs2, bit dv, bit [3:0] drd,
                              bit rdy, bit [15:0] pend, bit [4:0] outst, bit e);
    row_t r;
    r.name = name; r.v = v; r.fl = fl; r.we = we; r.rd = rd; r.lat = lat;
    r.u1 = u1; r.rs1 = rs1; r.u2 = u2; r.rs2 = rs2; r.dv = dv; r.drd = drd;
    r.exp = {rdy, pend, outst, e};
    return r;
  endfunction

  task automatic idle_inputs();
    issue_valid = 0; flush = 0; issue_we = 0; issue_rd = 0; issue_lat = 0;
    issue_rs1_used = 0; issue_rs1 = 0; issue_rs2_used = 0; issue_rs2 = 0;
    done_valid = 0; done_rd = 0;
  endtask

  task automatic drive(input row_t r);
    exp_t e;
    issue_valid = r.v; flush = r.fl; issue_we = r.we; issue_rd = r.rd; issue_lat = r.lat;
    issue_rs1_used = r.u1; issue_rs1 = r.rs1; issue_rs2_used = r.u2; issue_rs2 = r.rs2;
    done_valid = r.dv; done_rd = r.drd;
    e.name = r.name;
    e.val  = r.exp;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    bit [22:0] obs;
    rows.push_back(mk("reset_c0", 1,0,1,4'd1,3'd2, 0,0,0,0, 0,0, 1,16'h0000,5'd0,0));
    rows.push_back(mk("reset_c1", 1,0,1,4'd1,3'd2, 0,0,0,0, 0,0, 1,16'h0000,5'd0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = exp_q.pop_front();
      obs = {issue_ready, pending, outstanding, err};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("FAIL %s: got rdy=%0b pend=%h out=%0d err=%0b, expected rdy=%0b pend=%h out=%0d err=%0b",
                 e.name, obs[22], obs[21:6], obs[5:1], obs[0], e.val[22], e.val[21:6], e.val[5:1], e.val[0]);
      end else $display("ok   %s rdy=%0b pend=%h out=%0d err=%0b", e.name, obs[22], obs[21:6], obs[5:1], obs[0]);
      @(posedge clk); #1;
    end
    idle_inputs();
    #3 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_raw_fixed();
    row_t rows[$];
    exp_t e;
    bit [22:0] obs;
    rows.push_back(mk("raw_issue",  1,0,1,4'd3,3'd2, 0,0,0,0,      0,0, 1,16'h0000,5'd0,0));
    rows.push_back(mk("raw_stall",  1,0,0,4'd0,3'd0, 1,4'd3,0,0,   0,0, 0,16'h0008,5'd1,0));
    rows.push_back(mk("raw_bypass", 1,0,0,4'd0,3'd0, 1,4'd3,0,0,   0,0, 1,16'h0008,5'd1,0));
    rows.push_back(mk("raw_clear",  0,0,0,4'd0,3'd0, 0,0,0,0,      0,0, 1,16'h0000,5'd0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = exp_q.pop_front();
      obs = {issue_ready, pending, outstanding, err};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("FAIL %s: got rdy=%0b pend=%h out=%0d err=%0b, expected rdy=%0b pend=%h out=%0d err=%0b",
                 e.name, obs[22], obs[21:6], obs[5:1], obs[0], e.val[22], e.val[21:6], e.val[5:1], e.val[0]);
      end else $display("ok   %s rdy=%0b pend=%h out=%0d err=%0b", e.name, obs[22], obs[21:6], obs[5:1], obs[0]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_variable();
    row_t rows[$];
    exp_t e;
    bit [22:0] obs;
    rows.push_back(mk("var_issue",  1,0,1,4'd5,3'd0, 0,0,0,0,      0,0,    1,16'h0000,5'd0,0));
    rows.push_back(mk("var_wait0",  1,0,0,4'd0,3'd0, 0,0,1,4'd5,   0,0,    0,16'h0020,5'd1,0));
    rows.push_back(mk("var_wait1",  1,0,0,4'd0,3'd0, 0,0,1,4'd5,   0,0,    0,16'h0020,5'd1,0));
    rows.push_back(mk("var_wait2",  1,0,0,4'd0,3'd0, 0,0,1,4'd5,   0,0,    0,16'h0020,5'd1,0));
    rows.push_back(mk("var_done",   1,0,0,4'd0,3'd0, 0,0,1,4'd5,   1,4'd5, 1,16'h0020,5'd1,0));
    rows.push_back(mk("var_clear",  0,0,0,4'd0,3'd0, 0,0,0,0,      0,0,    1,16'h0000,5'd0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = exp_q.pop_front();
      obs = {issue_ready, pending, outstanding, err};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("FAIL %s: got rdy=%0b pend=%h out=%0d err=%0b, expected rdy=%0b pend=%h out=%0d err=%0b",
                 e.name, obs[22], obs[21:6], obs[5:1], obs[0], e.val[22], e.val[21:6], e.val[5:1], e.val[0]);
      end else $display("ok   %s rdy=%0b pend=%h out=%0d err=%0b", e.name, obs[22], obs[21:6], obs[5:1], obs[0]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_capacity();
    row_t rows[$];
    exp_t e;
    bit [22:0] obs;
    rows.push_back(mk("cap_rd1",     1,0,1,4'd1,3'd0, 0,0,0,0,       0,0,    1,16'h0000,5'd0,0));
    rows.push_back(mk("cap_rd2",     1,0,1,4'd2,3'd0, 0,0,0,0,       0,0,    1,16'h0002,5'd1,0));
    rows.push_back(mk("cap_rd3",     1,0,1,4'd3,3'd0, 0,0,0,0,       0,0,    1,16'h0006,5'd2,0));
    rows.push_back(mk("cap_rd4",     1,0,1,4'd4,3'd0, 0,0,0,0,       0,0,    1,16'h000E,5'd3,0));
    rows.push_back(mk("cap_full",    1,0,1,4'd6,3'd1, 0,0,0,0,       0,0,    0,16'h001E,5'd4,0));
    rows.push_back(mk("cap_readonly",1,0,0,4'd0,3'd0, 1,4'd7,1,4'd8, 0,0,    1,16'h001E,5'd4,0));
    rows.push_back(mk("cap_rawhaz",  1,0,0,4'd0,3'd0, 1,4'd2,0,0,    0,0,    0,16'h001E,5'd4,0));
    rows.push_back(mk("cap_release", 1,0,1,4'd6,3'd1, 0,0,0,0,       1,4'd1, 1,16'h001E,5'd4,0));
    rows.push_back(mk("cap_done2",   0,0,0,4'd0,3'd0, 0,0,0,0,       1,4'd2, 1,16'h005C,5'd4,0));
    rows.push_back(mk("cap_done3",   0,0,0,4'd0,3'd0, 0,0,0,0,       1,4'd3, 1,16'h0018,5'd2,0));
    rows.push_back(mk("cap_done4",   0,0,0,4'd0,3'd0, 0,0,0,0,       1,4'd4, 1,16'h0010,5'd1,0));
    rows.push_back(mk("cap_empty",   0,0,0,4'd0,3'd0, 0,0,0,0,       0,0,    1,16'h0000,5'd0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = exp_q.pop_front();
      obs = {issue_ready, pending, outstanding, err};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("FAIL %s: got rdy=%0b pend=%h out=%0d err=%0b, expected rdy=%0b pend=%h out=%0d err=%0b",
                 e.name, obs[22], obs[21:6], obs[5:1], obs[0], e.val[22], e.val[21:6], e.val[5:1], e.val[0]);
      end else $display("ok   %s rdy=%0b pend=%h out=%0d err=%0b", e.name, obs[22], obs[21:6], obs[5:1], obs[0]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    bit [22:0] obs;
    rows.push_back(mk("b2b_issue",   1,0,1,4'd9,3'd1, 0,0,0,0,     0,0, 1,16'h0000,5'd0,0));
    rows.push_back(mk("b2b_reissue", 1,0,1,4'd9,3'd2, 1,4'd9,0,0,  0,0, 1,16'h0200,5'd1,0));
    rows.push_back(mk("b2b_stall",   1,0,0,4'd0,3'd0, 1,4'd9,0,0,  0,0, 0,16'h0200,5'd1,0));
    rows.push_back(mk("b2b_bypass",  1,0,0,4'd0,3'd0, 1,4'd9,0,0,  0,0, 1,16'h0200,5'd1,0));
    rows.push_back(mk("b2b_clear",   0,0,0,4'd0,3'd0, 0,0,0,0,     0,0, 1,16'h0000,5'd0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = exp_q.pop_front();
      obs = {issue_ready, pending, outstanding, err};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("FAIL %s: got rdy=%0b pend=%h out=%0d err=%0b, expected rdy=%0b pend=%h out=%0d err=%0b",
                 e.name, obs[22], obs[21:6], obs[5:1], obs[0], e.val[22], e.val[21:6], e.val[5:1], e.val[0]);
      end else $display("ok   %s rdy=%0b pend=%h out=%0d err=%0b", e.name, obs[22], obs[21:6], obs[5:1], obs[0]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rd_zero();
    row_t rows[$];
    exp_t e;
    bit [22:0] obs;
    rows.push_back(mk("rd0_issue", 1,0,1,4'd0,3'd3, 0,0,0,0,    0,0, 1,16'h0000,5'd0,0));
    rows.push_back(mk("rd0_read",  1,0,0,4'd0,3'd0, 1,4'd0,0,0, 0,0, 1,16'h0000,5'd0,0));
    rows.push_back(mk("rd0_after", 0,0,0,4'd0,3'd0, 0,0,0,0,    0,0, 1,16'h0000,5'd0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = exp_q.pop_front();
      obs = {issue_ready, pending, outstanding, err};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("FAIL %s: got rdy=%0b pend=%h out=%0d err=%0b, expected rdy=%0b pend=%h out=%0d err=%0b",
                 e.name, obs[22], obs[21:6], obs[5:1], obs[0], e.val[22], e.val[21:6], e.val[5:1], e.val[0]);
      end else $display("ok   %s rdy=%0b pend=%h out=%0d err=%0b", e.name, obs[22], obs[21:6], obs[5:1], obs[0]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_err();
    row_t rows[$];
    exp_t e;
    bit [22:0] obs;
    rows.push_back(mk("flush_issue", 1,1,1,4'd7,3'd2, 0,0,0,0, 0,0,    1,16'h0000,5'd0,0));
    rows.push_back(mk("err_done9",   0,0,0,4'd0,3'd0, 0,0,0,0, 1,4'd9, 1,16'h0000,5'd0,0));
    rows.push_back(mk("err_set",     0,0,0,4'd0,3'd0, 0,0,0,0, 0,0,    1,16'h0000,5'd0,1));
    rows.push_back(mk("err_sticky",  0,0,0,4'd0,3'd0, 0,0,0,0, 0,0,    1,16'h0000,5'd0,1));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = exp_q.pop_front();
      obs = {issue_ready, pending, outstanding, err};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("FAIL %s: got rdy=%0b pend=%h out=%0d err=%0b, expected rdy=%0b pend=%h out=%0d err=%0b",
                 e.name, obs[22], obs[21:6], obs[5:1], obs[0], e.val[22], e.val[21:6], e.val[5:1], e.val[0]);
      end else $display("ok   %s rdy=%0b pend=%h out=%0d err=%0b", e.name, obs[22], obs[21:6], obs[5:1], obs[0]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    exp_t e;
    bit [22:0] obs;
    rows.push_back(mk("ar_issue",   1,0,1,4'd2,3'd7, 0,0,0,0, 0,0, 1,16'h0000,5'd0,1));
    rows.push_back(mk("ar_pending", 0,0,0,4'd0,3'd0, 0,0,0,0, 0,0, 1,16'h0004,5'd1,1));
    rows.push_back(mk("ar_inreset", 0,0,0,4'd0,3'd0, 0,0,0,0, 0,0, 1,16'h0000,5'd0,0));
    rows.push_back(mk("ar_reissue", 1,0,1,4'd2,3'd7, 0,0,0,0, 0,0, 1,16'h0000,5'd0,0));
    rows.push_back(mk("ar_first",   0,0,0,4'd0,3'd0, 0,0,0,0, 0,0, 1,16'h0004,5'd1,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      // Third row: pull reset low between edges and sample before any clock edge.
      if (i == 2) begin
        #1 rst = 1'b0;
      end
      #1;
      e = exp_q.pop_front();
      obs = {issue_ready, pending, outstanding, err};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("FAIL %s: got rdy=%0b pend=%h out=%0d err=%0b, expected rdy=%0b pend=%h out=%0d err=%0b",
                 e.name, obs[22], obs[21:6], obs[5:1], obs[0], e.val[22], e.val[21:6], e.val[5:1], e.val[0]);
      end else $display("ok   %s rdy=%0b pend=%h out=%0d err=%0b", e.name, obs[22], obs[21:6], obs[5:1], obs[0]);
      if (i == 2) begin
        #1 rst = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #1;
    test_reset();
    test_raw_fixed();
    test_variable();
    test_capacity();
    test_back_to_back();
    test_rd_zero();
    test_flush_err();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
